// File: rtl/reorder_buffer.sv
// reorder_buffer: circular buffer that tracks in-flight instructions from
// dispatch to in-order retirement, with CDB writeback, operand lookup and
// misprediction flush.
module reorder_buffer #(
    parameter int unsigned ROB_LOG = 4,
    parameter int unsigned NUM_WB  = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [4:0]                issue_dest,
    input  logic                      issue_ready,
    input  logic [XLEN-1:0]           issue_value,
    input  logic [XLEN-1:0]           issue_pred_pc,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ROB_LOG-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]    wb_value,
    input  logic [NUM_WB*XLEN-1:0]    wb_topc,
    input  logic [2*ROB_LOG-1:0]      qry_tag,
    output logic [1:0]                qry_ready,
    output logic [2*XLEN-1:0]         qry_value,
    output logic [ROB_LOG-1:0]        rob_next,
    output logic                      rob_next_full,
    output logic                      commit_valid,
    output logic [ROB_LOG-1:0]        commit_tag,
    output logic [1:0]                commit_type,
    output logic [4:0]                commit_dest,
    output logic [XLEN-1:0]           commit_value,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc
);
    localparam int unsigned DEPTH = 1 << ROB_LOG;
    localparam int unsigned PTR_W = ROB_LOG + 1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_JALR   = 2'd3;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, count_c;
    logic [ROB_LOG-1:0] head_idx_c, tail_idx_c;
    logic [DEPTH-1:0]   busy_q, busy_d, ready_q, ready_d;
    logic [1:0]         type_q  [DEPTH];
    logic [4:0]         dest_q  [DEPTH];
    logic [XLEN-1:0]    value_q [DEPTH];
    logic [XLEN-1:0]    topc_q  [DEPTH];
    logic [XLEN-1:0]    pred_q  [DEPTH];

    logic [DEPTH-1:0]   wb_hit_c, wb_we_c;
    logic [XLEN-1:0]    wb_val_c  [DEPTH];
    logic [XLEN-1:0]    wb_topc_c [DEPTH];
    logic [ROB_LOG-1:0] qt_c      [2];

    logic full_c, do_commit_c, mispred_c, do_flush_c, do_issue_c;

    logic               commit_valid_q, commit_valid_d;
    logic [ROB_LOG-1:0] commit_tag_q, commit_tag_d;
    logic [1:0]         commit_type_q, commit_type_d;
    logic [4:0]         commit_dest_q, commit_dest_d;
    logic [XLEN-1:0]    commit_value_q, commit_value_d;
    logic               flush_q, flush_d;
    logic [XLEN-1:0]    flush_pc_q, flush_pc_d;

    // Pointer arithmetic and per-cycle commit/flush/issue decisions
    always_comb begin
        head_idx_c  = head_q[ROB_LOG-1:0];
        tail_idx_c  = tail_q[ROB_LOG-1:0];
        count_c     = tail_q - head_q;
        full_c      = (head_idx_c == tail_idx_c) && (head_q[ROB_LOG] != tail_q[ROB_LOG]);
        do_commit_c = rdy && busy_q[head_idx_c] && ready_q[head_idx_c];
        mispred_c   = ((type_q[head_idx_c] == TYPE_BRANCH) || (type_q[head_idx_c] == TYPE_JALR))
                      && (topc_q[head_idx_c] != pred_q[head_idx_c]);
        do_flush_c  = do_commit_c && mispred_c;
        do_issue_c  = rdy && issue_valid && !full_c && !do_flush_c;
    end

    assign rob_next      = tail_idx_c;
    assign rob_next_full = (count_c >= PTR_W'(DEPTH - 1));

    // Per-entry writeback match; iterating high to low lets channel 0 win
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            wb_hit_c[i]  = 1'b0;
            wb_val_c[i]  = '0;
            wb_topc_c[i] = '0;
            for (int k = int'(NUM_WB) - 1; k >= 0; k--) begin
                if (wb_valid[k] && (wb_tag[k*ROB_LOG +: ROB_LOG] == ROB_LOG'(i))) begin
                    wb_hit_c[i]  = 1'b1;
                    wb_val_c[i]  = wb_value[k*XLEN +: XLEN];
                    wb_topc_c[i] = wb_topc[k*XLEN +: XLEN];
                end
            end
        end
        wb_we_c = wb_hit_c & busy_q & ~ready_q & {DEPTH{rdy}};
    end

    // Operand lookup with same-cycle CDB forwarding
    always_comb begin
        qry_ready = '0;
        qry_value = '0;
        for (int q = 0; q < 2; q++) begin
            qt_c[q] = qry_tag[q*ROB_LOG +: ROB_LOG];
            qry_ready[q] = ready_q[qt_c[q]] || wb_hit_c[qt_c[q]];
            if (!ready_q[qt_c[q]] && wb_hit_c[qt_c[q]]) begin
                qry_value[q*XLEN +: XLEN] = wb_val_c[qt_c[q]];
            end else begin
                qry_value[q*XLEN +: XLEN] = value_q[qt_c[q]];
            end
        end
    end

    // Next state for pointers, entry flags and registered outputs
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        busy_d         = busy_q;
        ready_d        = ready_q | wb_we_c;
        commit_valid_d = 1'b0;
        commit_tag_d   = commit_tag_q;
        commit_type_d  = commit_type_q;
        commit_dest_d  = commit_dest_q;
        commit_value_d = commit_value_q;
        flush_d        = 1'b0;
        flush_pc_d     = flush_pc_q;
        if (do_commit_c) begin
            commit_valid_d      = 1'b1;
            commit_tag_d        = head_idx_c;
            commit_type_d       = type_q[head_idx_c];
            commit_dest_d       = dest_q[head_idx_c];
            commit_value_d      = value_q[head_idx_c];
            busy_d[head_idx_c]  = 1'b0;
            ready_d[head_idx_c] = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (do_issue_c) begin
            busy_d[tail_idx_c]  = 1'b1;
            ready_d[tail_idx_c] = issue_ready;
            tail_d              = tail_q + PTR_W'(1);
        end
        if (do_flush_c) begin
            flush_d    = 1'b1;
            flush_pc_d = topc_q[head_idx_c];
            busy_d     = '0;
            ready_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_type_q  <= '0;
            commit_dest_q  <= '0;
            commit_value_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_tag_q   <= commit_tag_d;
            commit_type_q  <= commit_type_d;
            commit_dest_q  <= commit_dest_d;
            commit_value_q <= commit_value_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Entry payload storage; validity is tracked by busy/ready only
    always_ff @(posedge clk) begin
        if (do_issue_c) begin
            type_q[tail_idx_c]  <= issue_type;
            dest_q[tail_idx_c]  <= issue_dest;
            value_q[tail_idx_c] <= issue_value;
            topc_q[tail_idx_c]  <= issue_pred_pc;
            pred_q[tail_idx_c]  <= issue_pred_pc;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wb_we_c[i]) begin
                value_q[i] <= wb_val_c[i];
                topc_q[i]  <= wb_topc_c[i];
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_tag   = commit_tag_q;
    assign commit_type  = commit_type_q;
    assign commit_dest  = commit_dest_q;
    assign commit_value = commit_value_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic, compared against
// a program-order queue model of the reorder buffer.
module tb_reorder_buffer;
    localparam int ROB_LOG = 4;
    localparam int NUM_WB  = 2;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic rst, rdy, issue_valid, issue_ready;
    logic [1:0]                issue_type;
    logic [4:0]                issue_dest;
    logic [XLEN-1:0]           issue_value, issue_pred_pc;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*ROB_LOG-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]    wb_value, wb_topc;
    logic [2*ROB_LOG-1:0]      qry_tag;
    logic [1:0]                qry_ready;
    logic [2*XLEN-1:0]         qry_value;
    logic [ROB_LOG-1:0]        rob_next;
    logic                      rob_next_full;
    logic                      commit_valid;
    logic [ROB_LOG-1:0]        commit_tag;
    logic [1:0]                commit_type;
    logic [4:0]                commit_dest;
    logic [XLEN-1:0]           commit_value;
    logic                      flush;
    logic [XLEN-1:0]           flush_pc;

    reorder_buffer #(.ROB_LOG(ROB_LOG), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_dest(issue_dest),
        .issue_ready(issue_ready), .issue_value(issue_value), .issue_pred_pc(issue_pred_pc),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_topc(wb_topc),
        .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_value(qry_value),
        .rob_next(rob_next), .rob_next_full(rob_next_full),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_type(commit_type),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions in program order
    typedef struct {
        int          tag;
        logic [1:0]  typ;
        logic [4:0]  dest;
        bit          rdy;
        logic [31:0] value;
        logic [31:0] topc;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    int          m_next;
    bit          e_cv, e_fl;
    int          e_ctag;
    logic [1:0]  e_ctype;
    logic [4:0]  e_cdest;
    logic [31:0] e_cval, e_fpc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          log_tag[$];
    int          log_cyc[$];
    logic [31:0] log_val[$];
    int          n_flush;
    logic [31:0] last_fpc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1;
        issue_valid = 1'b0; issue_type = '0; issue_dest = '0; issue_ready = 1'b0;
        issue_value = '0; issue_pred_pc = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_topc = '0; qry_tag = '0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] d, input bit r,
                             input logic [31:0] v, input logic [31:0] p);
        issue_valid = 1'b1; issue_type = t; issue_dest = d; issue_ready = r;
        issue_value = v; issue_pred_pc = p;
    endtask

    task automatic set_wb(input int k, input int tag, input logic [31:0] v, input logic [31:0] pc);
        wb_valid[k] = 1'b1;
        wb_tag[k*ROB_LOG +: ROB_LOG] = ROB_LOG'(tag);
        wb_value[k*XLEN +: XLEN] = v;
        wb_topc[k*XLEN +: XLEN] = pc;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        int   sz0;
        bit   do_c;
        bit   mis;
        ent_t c;
        if (rst) begin
            mq.delete(); m_next = 0;
            e_cv = 0; e_fl = 0; e_ctag = 0; e_ctype = '0; e_cdest = '0; e_cval = '0; e_fpc = '0;
            return;
        end
        e_cv = 0; e_fl = 0;
        if (!rdy) return;
        sz0  = mq.size();
        do_c = (sz0 > 0) && mq[0].rdy;
        mis  = 0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(wb_tag[k*ROB_LOG +: ROB_LOG]) && !mq[i].rdy) begin
                        mq[i].rdy   = 1;
                        mq[i].value = wb_value[k*XLEN +: XLEN];
                        mq[i].topc  = wb_topc[k*XLEN +: XLEN];
                    end
                end
            end
        end
        if (do_c) begin
            c = mq.pop_front();
            e_cv = 1; e_ctag = c.tag; e_ctype = c.typ; e_cdest = c.dest; e_cval = c.value;
            mis = (c.typ >= 2) && (c.topc != c.pred);
        end
        if (mis) begin
            e_fl = 1; e_fpc = c.topc;
            mq.delete(); m_next = 0;
        end else if (issue_valid && sz0 < DEPTH) begin
            mq.push_back('{tag: m_next, typ: issue_type, dest: issue_dest, rdy: issue_ready,
                           value: issue_value, topc: issue_pred_pc, pred: issue_pred_pc});
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    task automatic check_comb();
        chk("rob_next", 64'(rob_next), 64'(m_next));
        chk("rob_next_full", 64'(rob_next_full), 64'(mq.size() >= DEPTH - 1));
        for (int q = 0; q < 2; q++) begin
            int          t;
            bit          er;
            bit          found;
            logic [31:0] ev;
            t = int'(qry_tag[q*ROB_LOG +: ROB_LOG]);
            er = 0; found = 0; ev = '0;
            foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) begin er = 1; found = 1; ev = mq[i].value; end
            if (!found) begin
                for (int k = NUM_WB - 1; k >= 0; k--) begin
                    if (wb_valid[k] && int'(wb_tag[k*ROB_LOG +: ROB_LOG]) == t) begin
                        er = 1; ev = wb_value[k*XLEN +: XLEN];
                    end
                end
            end
            chk($sformatf("qry_ready%0d", q), 64'(qry_ready[q]), 64'(er));
            if (er) chk($sformatf("qry_value%0d", q), 64'(qry_value[q*XLEN +: XLEN]), 64'(ev));
        end
    endtask

    task automatic check_reg();
        chk("commit_valid", 64'(commit_valid), 64'(e_cv));
        chk("commit_tag",   64'(commit_tag),   64'(e_ctag));
        chk("commit_type",  64'(commit_type),  64'(e_ctype));
        chk("commit_dest",  64'(commit_dest),  64'(e_cdest));
        chk("commit_value", 64'(commit_value), 64'(e_cval));
        chk("flush",        64'(flush),        64'(e_fl));
        chk("flush_pc",     64'(flush_pc),     64'(e_fpc));
        if (commit_valid) begin
            log_tag.push_back(int'(commit_tag));
            log_val.push_back(commit_value);
            log_cyc.push_back(cyc);
        end
        if (flush) begin
            n_flush++;
            last_fpc = flush_pc;
        end
    endtask

    // One cycle: inputs are driven at the falling edge before this call
    task automatic step();
        #1;
        check_comb();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_reg();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        log_tag.delete(); log_val.delete(); log_cyc.delete();
        n_flush = 0; last_fpc = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); idle(); clear_logs();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_edge();
        chk("rst_commit_valid",  64'(commit_valid),  64'(0));
        chk("rst_commit_tag",    64'(commit_tag),    64'(0));
        chk("rst_commit_value",  64'(commit_value),  64'(0));
        chk("rst_flush",         64'(flush),         64'(0));
        chk("rst_flush_pc",      64'(flush_pc),      64'(0));
        chk("rst_rob_next",      64'(rob_next),      64'(0));
        chk("rst_rob_next_full", 64'(rob_next_full), 64'(0));
        idle(); clear_logs();

        // Out-of-order writeback, in-order retirement
        for (int i = 0; i < 3; i++) begin
            idle(); set_issue(2'd0, 5'(i + 1), 1'b0, '0, '0); step();
        end
        idle(); set_wb(0, 2, 32'hA, '0); step();
        idle(); set_wb(0, 0, 32'hB, '0); step();
        idle(); set_wb(0, 1, 32'hC, '0); step();
        idle(); repeat (3) step();
        chk("t1_ncommit", 64'(log_val.size()), 64'(3));
        if (log_val.size() == 3) begin
            chk("t1_val0", 64'(log_val[0]), 64'(32'hB));
            chk("t1_val1", 64'(log_val[1]), 64'(32'hC));
            chk("t1_val2", 64'(log_val[2]), 64'(32'hA));
            chk("t1_tag2", 64'(log_tag[2]), 64'(2));
            chk("t1_back2back", 64'(log_cyc[2] - log_cyc[0]), 64'(2));
        end

        // Fill to capacity; extra issues are dropped
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            idle(); set_issue(2'd0, 5'(i), 1'b0, '0, '0); step();
        end
        #1 chk("t2_almost_full", 64'(rob_next_full), 64'(1));
        idle(); set_issue(2'd0, 5'd20, 1'b0, '0, '0); step();
        idle(); set_issue(2'd0, 5'd21, 1'b0, '0, '0); step();
        idle(); set_issue(2'd0, 5'd22, 1'b0, '0, '0); step();
        #1 chk("t2_tail_wrapped", 64'(rob_next), 64'(0));
        chk("t2_still_full", 64'(rob_next_full), 64'(1));

        // Two channels hit the same tag: channel 0 wins, query forwards it
        idle(); set_wb(0, 5, 32'h11, '0); set_wb(1, 5, 32'h22, '0);
        qry_tag = 8'h05;
        #1 chk("t3_fwd_ready", 64'(qry_ready[0]), 64'(1));
        chk("t3_fwd_value", 64'(qry_value[XLEN-1:0]), 64'(32'h11));
        step();
        idle(); qry_tag = 8'h05;
        #1 chk("t3_stored_value", 64'(qry_value[XLEN-1:0]), 64'(32'h11));
        for (int t = 0; t < DEPTH; t += 2) begin
            idle(); set_wb(0, t, 32'(t * 3), '0); set_wb(1, t + 1, 32'(t * 5 + 1), '0); step();
        end
        idle(); repeat (20) step();
        chk("t3_drained", 64'(log_val.size()), 64'(DEPTH));

        // Mispredicted branch at head flushes younger entries
        do_reset();
        idle(); set_issue(2'd2, 5'd0, 1'b0, '0, 32'h100); step();
        idle(); set_issue(2'd0, 5'd5, 1'b1, 32'h55, '0); step();
        idle(); set_issue(2'd0, 5'd6, 1'b1, 32'h66, '0); step();
        idle(); set_wb(0, 0, 32'h44, 32'h200); step();
        idle(); set_issue(2'd0, 5'd7, 1'b1, 32'h77, '0); step();
        idle(); repeat (3) step();
        chk("t4_commits", 64'(log_tag.size()), 64'(1));
        chk("t4_flushes", 64'(n_flush), 64'(1));
        chk("t4_flush_pc", 64'(last_fpc), 64'(32'h200));
        #1 chk("t4_rob_next", 64'(rob_next), 64'(0));
        idle(); set_issue(2'd0, 5'd8, 1'b0, '0, '0); step();
        #1 chk("t4_reissue", 64'(rob_next), 64'(1));

        // Sustained issue/commit wraps the tag space several times
        do_reset();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            idle(); set_issue(2'd0, 5'(i % 32), 1'b1, 32'(i), '0); step();
        end
        idle(); repeat (2) step();
        chk("t5_ncommit", 64'(log_tag.size()), 64'(3 * DEPTH));
        foreach (log_tag[i]) chk($sformatf("t5_tag%0d", i), 64'(log_tag[i]), 64'(i % DEPTH));

        // Stall with a ready head entry
        do_reset();
        idle(); set_issue(2'd0, 5'd9, 1'b1, 32'h99, '0); step();
        idle(); rdy = 1'b0; repeat (4) step();
        chk("t6_no_commit_stalled", 64'(log_val.size()), 64'(0));
        idle(); step();
        chk("t6_commit_after", 64'(log_val.size()), 64'(1));

        // Random traffic
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 2) != 0) begin
                logic [1:0] ty;
                ty = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
                set_issue(ty, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                          $urandom, 32'h100 + 32'($urandom_range(0, 1)) * 4);
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    if (mq.size() > 0 && $urandom_range(0, 4) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
                    else t = $urandom_range(0, DEPTH - 1);
                    set_wb(k, t, $urandom, 32'h100 + 32'($urandom_range(0, 1)) * 4);
                end
            end
            qry_tag = 8'($urandom_range(0, 255));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised circular reorder buffer for the out-of-order RV32I core. It sits between dispatch, which allocates entries, and the register file and LSB, which receive commits. It accepts completion results on NUM_WB parallel CDB channels and retires one entry per cycle in program order. On a mispredicted branch at the head it commits that branch, then issues a one-cycle global flush with the redirect PC.

Parameters:
ROB_LOG, 4, log2 of entry count; DEPTH = 2**ROB_LOG
NUM_WB, 2, number of CDB writeback channels
XLEN, 32, data/PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state
issue_valid  in  1  allocate entry at tail this cycle
issue_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=JALR
issue_dest  in  5  destination register (REG/JALR)
issue_ready  in  1  entry already complete at issue (e.g. LUI)
issue_value  in  XLEN  value when issue_ready
issue_pred_pc  in  XLEN  predicted next PC (BRANCH/JALR)
wb_valid  in  NUM_WB  per-channel result valid
wb_tag  in  NUM_WB*ROB_LOG  entry tag per channel (channel k at bits [k*ROB_LOG +: ROB_LOG])
wb_value  in  NUM_WB*XLEN  result value per channel
wb_topc  in  NUM_WB*XLEN  resolved next PC per channel (BRANCH/JALR)
qry_tag  in  2*ROB_LOG  two operand lookup tags
qry_ready  out  2  entry ready, per lookup
qry_value  out  2*XLEN  entry value, per lookup
rob_next  out  ROB_LOG  tag the next issued entry will receive (= tail index)
rob_next_full  out  1  count >= DEPTH-1; dispatch must not issue next cycle
commit_valid  out  1  one-cycle commit pulse
commit_tag  out  ROB_LOG  committed entry tag
commit_type  out  2  committed entry type
commit_dest  out  5  destination register
commit_value  out  XLEN  committed value
flush  out  1  one-cycle misprediction flush
flush_pc  out  XLEN  redirect PC, valid with flush

Behaviour:
- Storage: head/tail are ROB_LOG+1 bits; the extra MSB is the wrap bit. count = tail - head. Empty when head == tail; full when the index bits are equal and the wrap bits differ. Per entry: busy, ready, type, dest, value, topc, pred_pc.
- Reset: head=tail=0, all busy/ready=0. Every registered output is 0: commit_valid, commit_*, flush, flush_pc. rob_next=0, rob_next_full=0.
- rdy low: no state change. Registered outputs hold their values. commit_valid and flush are forced 0 that cycle.
- Issue: when issue_valid, write the entry at tail[ROB_LOG-1:0], set busy=1, set ready=issue_ready, then tail+1. Issue while full is a dispatch bug; the ROB ignores it and does not corrupt state. rob_next_full is combinational, which gives dispatch one cycle of slack.
- Writeback: for each channel k with wb_valid[k] and entry busy and not ready, set ready=1 and store value/topc. If two channels target the same tag, the lowest k wins. Writeback to a non-busy entry is ignored. Mispredicted = (topc != pred_pc) for BRANCH/JALR.
- Query: combinational. qry_ready = ready, or a matching wb_valid this cycle (forwarded, lowest k wins). qry_value follows the same forwarding rule.
- Commit: if the head entry is busy and ready (registered state, not same-cycle writeback), then on the next edge: commit_valid=1, commit_* = entry fields, busy=0, head+1. At most one commit per cycle. Commit latency is 1 cycle after ready is registered.
- Flush: if the committing entry is mispredicted, then at the same edge as commit_valid: flush=1 and flush_pc=topc. All entries are cleared, head=tail=0, and any same-cycle issue is dropped. flush lasts exactly one cycle. The next cycle accepts issue normally.
- Simultaneous issue and commit while full: commit frees an entry but issue is still rejected, because full is evaluated before the edge.
- Wrap-around: indices wrap mod DEPTH and the wrap bit toggles. Tags are index bits only.
- rst overrides everything, including mid-flush or mid-commit.

Test Plan:
- Reset, then issue 3 REG entries (dest 1,2,3), WB tags 2,0,1 out of order with values 0xA,0xB,0xC -> commits in order: tag0 dest1=0xB, tag1 dest2=0xC, tag2 dest3=0xA, on consecutive cycles.
- Issue DEPTH-1 entries without WB -> rob_next_full=1. Issue one more -> count=DEPTH. Further issue_valid -> ignored, tail unchanged.
- Two channels write the same tag 5 with 0x11 (ch0) and 0x22 (ch1) -> entry 5 value=0x11. Query tag 5 that cycle -> qry_ready=1, qry_value=0x11.
- BRANCH pred_pc=0x100, WB topc=0x200, younger entries queued -> commit_valid, flush=1, flush_pc=0x200 for one cycle, then head=tail=0 and the younger entries are never committed.
- Run 3*DEPTH issue/commit pairs -> tags wrap correctly and commit_tag sequence is 0..DEPTH-1 repeating.
- Hold rdy=0 for 4 cycles while head is ready -> no commit and no state change. On rdy=1 -> commit next cycle.
